// File: rtl/hs_sync_rx_ctrl.sv
// rtl/hs_sync_rx_ctrl.sv - destination-side 4-phase req/ack CDC receiver with valid/ready output
// Synchronizes req_async, captures the source-held bus, and sequences ack back to the source.
module hs_sync_rx_ctrl #(
  parameter int NUM_STG = 2,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_async,
  input  logic [WIDTH-1:0] data_async,
  output logic             ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VALID    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [NUM_STG-1:0] sync_q;
  logic               req_s;
  logic               ack_nx;
  logic               out_valid_nx;
  logic               load_data;
  logic               cnt_inc;
  logic               err_set;

  assign req_s = sync_q[NUM_STG-1];
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sync_q    <= '0;
      ack       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      xfer_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nx;
      sync_q    <= {sync_q[NUM_STG-2:0], req_async};
      ack       <= ack_nx;
      out_valid <= out_valid_nx;
      // data_async is only trusted on the capture edge; the source holds it until ack
      if (load_data) out_data <= data_async;
      if (cnt_inc)   xfer_cnt <= xfer_cnt + 1'b1;
      if (err_set)   proto_err <= 1'b1;
    end
  end

  always_comb begin
    state_nx     = state;
    ack_nx       = ack;
    out_valid_nx = out_valid;
    load_data    = 1'b0;
    cnt_inc      = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (req_s) begin
          load_data    = 1'b1;
          out_valid_nx = 1'b1;
          state_nx     = VALID;
        end
      end
      VALID: begin
        // source withdrew req before we acked; flag it but finish the transfer
        if (!req_s) err_set = 1'b1;
        if (out_ready) begin
          out_valid_nx = 1'b0;
          ack_nx       = 1'b1;
          cnt_inc      = 1'b1;
          state_nx     = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!req_s) begin
          ack_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hs_sync_rx_ctrl.sv
// tb/tb_hs_sync_rx_ctrl.sv - scoreboard bench for hs_sync_rx_ctrl
module tb_hs_sync_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_async;
  logic [7:0] data_async;
  logic       ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic [3:0] xfer_cnt;
  logic       proto_err;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [3:0] exp_cnt = 4'd0;

  hs_sync_rx_ctrl #(.NUM_STG(2), .WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_async(req_async), .data_async(data_async),
    .ack(ack), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .xfer_cnt(xfer_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic pop_exp(output logic [7:0] e, output bit empty);
    empty = (exp_q.size() == 0);
    e = empty ? 8'h00 : exp_q.pop_front();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ok) begin
        @(negedge clk);
        ok = out_valid;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ok) begin
        @(negedge clk);
        ok = !busy && !ack;
      end
    end
  endtask

  task automatic do_xfer(input logic [7:0] d, output logic [7:0] got, output int pulses,
                         output bit ok);
    bit done;
    @(negedge clk);
    data_async = d; req_async = 1'b1; out_ready = 1'b1;
    exp_q.push_back(d);
    pulses = 0; got = 8'h00; ok = 1'b0; done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ok) begin
        @(negedge clk);
        if (out_valid) begin pulses++; got = out_data; end
        ok = ack;
      end
    end
    if (ok) exp_cnt++;
    req_async = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!done) begin
        @(negedge clk);
        if (out_valid) pulses++;
        done = !busy && !ack;
      end
    end
    ok = ok && done;
  endtask

  task automatic test_reset;
    rst = 1'b0; req_async = 1'b0; data_async = 8'h00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ack !== 1'b0)       begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
    total++; if (xfer_cnt !== 4'd0)  begin bad++; $display("FAIL reset_cnt got=%0d exp=0", xfer_cnt); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", proto_err); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b1;
  endtask

  task automatic test_single;
    logic [7:0] e; bit empty;
    @(negedge clk);
    data_async = 8'hA5; req_async = 1'b1; out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_e1_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_e2 valid=%b busy=%b exp=0,0", out_valid, busy); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || busy !== 1'b1 || ack !== 1'b0) begin bad++; $display("FAIL single_e3 valid=%b busy=%b ack=%b exp=1,1,0", out_valid, busy, ack); end
    pop_exp(e, empty);
    total++; if (empty || out_data !== e) begin bad++; $display("FAIL single_data got=%h exp=%h", out_data, e); end
    @(negedge clk);
    exp_cnt++;
    total++; if (out_valid !== 1'b0 || ack !== 1'b1) begin bad++; $display("FAIL single_e4 valid=%b ack=%b exp=0,1", out_valid, ack); end
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL single_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
    req_async = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL single_rel2 ack got=%b exp=1", ack); end
    @(negedge clk);
    total++; if (ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_rel3 ack=%b busy=%b exp=0,0", ack, busy); end
  endtask

  task automatic test_backpressure;
    logic [7:0] e; bit empty; bit ok;
    @(negedge clk);
    data_async = 8'h3C; req_async = 1'b1; out_ready = 1'b0;
    exp_q.push_back(8'h3C);
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_wait got=timeout exp=out_valid"); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || ack !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d valid=%b data=%h ack=%b exp=1,3c,0", k, out_valid, out_data, ack);
      end
      if (k == 1) data_async = 8'hFF;
      @(negedge clk);
    end
    out_ready = 1'b1;
    pop_exp(e, empty);
    total++; if (empty || out_data !== e) begin bad++; $display("FAIL bp_data got=%h exp=%h", out_data, e); end
    @(negedge clk);
    exp_cnt++;
    total++; if (ack !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_ack ack=%b valid=%b exp=1,0", ack, out_valid); end
    total++; if (xfer_cnt !== exp_cnt) begin bad++; $display("FAIL bp_cnt got=%0d exp=%0d", xfer_cnt, exp_cnt); end
    req_async = 1'b0;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_idle got=timeout exp=idle"); end
  endtask

  task automatic test_wrap;
    logic [7:0] e, got; bit empty; bit ok; int pulses;
    @(negedge clk);
    req_async = 1'b0; rst = 1'b0;
    exp_q.delete(); exp_cnt = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      do_xfer(8'(k * 37 + 11), got, pulses, ok);
      pop_exp(e, empty);
      total++;
      if (!ok || pulses != 1 || empty || got !== e) begin
        bad++; $display("FAIL wrap_xfer%0d ok=%b pulses=%0d data=%h exp ok=1 pulses=1 data=%h", k, ok, pulses, got, e);
      end
      if (k == 14) begin
        total++; if (xfer_cnt !== 4'd15) begin bad++; $display("FAIL wrap_cnt15 got=%0d exp=15", xfer_cnt); end
      end
    end
    total++; if (xfer_cnt !== 4'd0 || xfer_cnt !== exp_cnt) begin bad++; $display("FAIL wrap_cnt got=%0d exp=0", xfer_cnt); end
  endtask

  task automatic test_proto_err;
    logic [7:0] e, got; bit empty; bit ok; int pulses;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL perr_pre got=%b exp=0", proto_err); end
    @(negedge clk);
    data_async = 8'h5A; req_async = 1'b1; out_ready = 1'b0;
    exp_q.push_back(8'h5A);
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL perr_wait got=timeout exp=out_valid"); end
    req_async = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (proto_err !== 1'b1 || out_valid !== 1'b1 || ack !== 1'b0) begin bad++; $display("FAIL perr_set err=%b valid=%b ack=%b exp=1,1,0", proto_err, out_valid, ack); end
    out_ready = 1'b1;
    pop_exp(e, empty);
    total++; if (empty || out_data !== e) begin bad++; $display("FAIL perr_data got=%h exp=%h", out_data, e); end
    @(negedge clk);
    exp_cnt++;
    total++; if (ack !== 1'b1 || xfer_cnt !== exp_cnt) begin bad++; $display("FAIL perr_ack ack=%b cnt=%0d exp=1,%0d", ack, xfer_cnt, exp_cnt); end
    wait_idle(ok);
    total++; if (!ok || proto_err !== 1'b1) begin bad++; $display("FAIL perr_idle ok=%b err=%b exp=1,1", ok, proto_err); end
    do_xfer(8'hC7, got, pulses, ok);
    pop_exp(e, empty);
    total++; if (!ok || pulses != 1 || empty || got !== e) begin bad++; $display("FAIL perr_clean ok=%b pulses=%0d data=%h exp 1,1,%h", ok, pulses, got, e); end
    total++; if (proto_err !== 1'b1 || xfer_cnt !== exp_cnt) begin bad++; $display("FAIL perr_sticky err=%b cnt=%0d exp=1,%0d", proto_err, xfer_cnt, exp_cnt); end
  endtask

  task automatic test_reset_wait_rel;
    logic [7:0] e; bit empty; bit ok;
    @(negedge clk);
    data_async = 8'hC3; req_async = 1'b1; out_ready = 1'b1;
    exp_q.push_back(8'hC3);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ok) begin @(negedge clk); ok = ack; end
    end
    pop_exp(e, empty);
    total++; if (!ok || busy !== 1'b1 || empty || out_data !== e) begin bad++; $display("FAIL rwr_pre ack=%b busy=%b data=%h exp 1,1,%h", ack, busy, out_data, e); end
    data_async = 8'h96;
    #2 rst = 1'b0;
    exp_q.delete(); exp_cnt = 4'd0;
    #1;
    total++; if (ack !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rwr_rst ack=%b valid=%b busy=%b exp=0,0,0", ack, out_valid, busy); end
    total++; if (out_data !== 8'h00 || xfer_cnt !== 4'd0 || proto_err !== 1'b0) begin bad++; $display("FAIL rwr_rst data=%h cnt=%0d err=%b exp=00,0,0", out_data, xfer_cnt, proto_err); end
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(8'h96);
    @(negedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rwr_e2 valid got=%b exp=0", out_valid); end
    @(negedge clk);
    pop_exp(e, empty);
    total++; if (out_valid !== 1'b1 || empty || out_data !== e) begin bad++; $display("FAIL rwr_e3 valid=%b data=%h exp=1,%h", out_valid, out_data, e); end
    req_async = 1'b0;
    exp_cnt++;
    wait_idle(ok);
    total++; if (!ok || xfer_cnt !== exp_cnt) begin bad++; $display("FAIL rwr_done ok=%b cnt=%0d exp=1,%0d", ok, xfer_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_proto_err();
    test_reset_wait_rel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
